// File: rtl/sram_access_arbiter.sv
// Two-port round-robin arbiter and strobe sequencer for a byte-wide asynchronous SRAM.
// A granted transaction runs IDLE -> SETUP -> ACCESS -> RECOVER -> IDLE, with all
// outputs registered. A single down-counter times each non-idle state.
module sram_access_arbiter #(
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned ACCESS_CYC  = 2,
  parameter int unsigned RECOVER_CYC = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        we0,
  input  logic [20:0] addr0,
  input  logic [7:0]  wdata0,
  output logic        ack0,
  output logic [7:0]  rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [20:0] addr1,
  input  logic [7:0]  wdata1,
  output logic        ack1,
  output logic [7:0]  rdata1,
  output logic [20:0] sram_a,
  output logic [7:0]  sram_dq_w,
  input  logic [7:0]  sram_dq_r,
  output logic        sram_nce,
  output logic        sram_noe,
  output logic        sram_nwe,
  output logic        busy
);

  localparam int unsigned MaxSa  = (SETUP_CYC > ACCESS_CYC) ? SETUP_CYC : ACCESS_CYC;
  localparam int unsigned MaxCyc = (MaxSa > RECOVER_CYC) ? MaxSa : RECOVER_CYC;
  // Counter holds (cycles - 1), so it only needs to reach MaxCyc - 1.
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CntW-1:0] SetupLoad   = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] AccessLoad  = CntW'(ACCESS_CYC - 1);
  localparam logic [CntW-1:0] RecoverLoad = CntW'(RECOVER_CYC - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StRecover} state_e;

  state_e          r_state, w_state;
  logic [CntW-1:0] r_cnt, w_cnt;
  logic            r_we, w_we;
  logic            r_gnt, w_gnt;
  logic            r_last, w_last;
  logic [20:0]     r_sram_a, w_sram_a;
  logic [7:0]      r_dq_w, w_dq_w;
  logic            r_nce, w_nce;
  logic            r_noe, w_noe;
  logic            r_nwe, w_nwe;
  logic            r_ack0, w_ack0;
  logic            r_ack1, w_ack1;
  logic [7:0]      r_rdata0, w_rdata0;
  logic [7:0]      r_rdata1, w_rdata1;
  logic            r_busy, w_busy;
  logic            w_pick;

  // State, counter and every output register; reset drops strobes immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_gnt    <= 1'b0;
      r_last   <= 1'b1;
      r_sram_a <= '0;
      r_dq_w   <= '0;
      r_nce    <= 1'b1;
      r_noe    <= 1'b1;
      r_nwe    <= 1'b1;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_we     <= w_we;
      r_gnt    <= w_gnt;
      r_last   <= w_last;
      r_sram_a <= w_sram_a;
      r_dq_w   <= w_dq_w;
      r_nce    <= w_nce;
      r_noe    <= w_noe;
      r_nwe    <= w_nwe;
      r_ack0   <= w_ack0;
      r_ack1   <= w_ack1;
      r_rdata0 <= w_rdata0;
      r_rdata1 <= w_rdata1;
      r_busy   <= w_busy;
    end
  end

  // Next state and next registered outputs; strobe values are those for the coming cycle.
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_we     = r_we;
    w_gnt    = r_gnt;
    w_last   = r_last;
    w_sram_a = r_sram_a;
    w_dq_w   = r_dq_w;
    w_nce    = 1'b1;
    w_noe    = 1'b1;
    w_nwe    = 1'b1;
    w_ack0   = 1'b0;
    w_ack1   = 1'b0;
    w_rdata0 = r_rdata0;
    w_rdata1 = r_rdata1;
    // On a tie the port that was not served last wins.
    w_pick   = (req0 && req1) ? ~r_last : req1;

    unique case (r_state)
      StIdle: begin
        if (req0 || req1) begin
          w_gnt    = w_pick;
          w_last   = w_pick;
          w_we     = w_pick ? we1 : we0;
          w_sram_a = w_pick ? addr1 : addr0;
          w_dq_w   = w_pick ? wdata1 : wdata0;
          w_cnt    = SetupLoad;
          w_state  = StSetup;
          w_nce    = 1'b0;
        end
      end
      StSetup: begin
        w_nce = 1'b0;
        if (r_cnt == '0) begin
          w_state = StAccess;
          w_cnt   = AccessLoad;
          w_noe   = r_we;
          w_nwe   = ~r_we;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      StAccess: begin
        if (r_cnt == '0) begin
          w_state = StRecover;
          w_cnt   = RecoverLoad;
          w_ack0  = ~r_gnt;
          w_ack1  = r_gnt;
          if (!r_we) begin
            if (r_gnt) w_rdata1 = sram_dq_r;
            else       w_rdata0 = sram_dq_r;
          end
        end else begin
          w_cnt = r_cnt - 1'b1;
          w_nce = 1'b0;
          w_noe = r_we;
          w_nwe = ~r_we;
        end
      end
      StRecover: begin
        if (r_cnt == '0) w_state = StIdle;
        else             w_cnt   = r_cnt - 1'b1;
      end
      default: w_state = StIdle;
    endcase

    w_busy = (w_state != StIdle);
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign sram_a    = r_sram_a;
  assign sram_dq_w = r_dq_w;
  assign sram_nce  = r_nce;
  assign sram_noe  = r_noe;
  assign sram_nwe  = r_nwe;
  assign busy      = r_busy;

endmodule
